// File: rtl/pim_vec_engine.sv
`default_nettype none
// ============================================================================
// Module   : pim_vec_engine
// Brief    : Element-wise A op B -> D vector engine driving a shared RAM port.
// Revision : 1.0
// ============================================================================
module pim_vec_engine (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic [31:0] dst,
  input  logic [10:0] len,
  output logic        pim_sel,
  output logic [31:0] pim_addr,
  output logic [31:0] pim_wdata,
  output logic [3:0]  pim_wmask,
  output logic        pim_rstrb,
  input  logic [31:0] pim_rdata,
  input  logic        pim_rbusy,
  input  logic        pim_wbusy,
  output logic        busy,
  output logic        done
);

  localparam logic [1:0]  c_OP_ADD = 2'd0;
  localparam logic [1:0]  c_OP_SUB = 2'd1;
  localparam logic [1:0]  c_OP_AND = 2'd2;
  localparam logic [1:0]  c_OP_XOR = 2'd3;
  localparam logic [31:0] c_STRIDE = 32'd4;

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_GRANT = 4'd1,
    S_RD_A  = 4'd2,
    S_WT_A  = 4'd3,
    S_RD_B  = 4'd4,
    S_WT_B  = 4'd5,
    S_WR    = 4'd6,
    S_WT_W  = 4'd7,
    S_FIN   = 4'd8
  } state_t;

  state_t      r_state;
  logic [1:0]  r_op;
  logic [31:0] r_ptr_a;
  logic [31:0] r_ptr_b;
  logic [31:0] r_ptr_d;
  logic [10:0] r_count;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic        r_sel;
  logic [31:0] r_addr;
  logic        r_rstrb;
  logic [3:0]  r_wmask;
  logic        r_done;

  logic [31:0] w_result;
  logic        w_last;
  logic        w_wr_phase;

  always_comb begin
    w_result = 32'd0;
    case (r_op)
      c_OP_ADD: w_result = r_a + r_b;
      c_OP_SUB: w_result = r_a - r_b;
      c_OP_AND: w_result = r_a & r_b;
      c_OP_XOR: w_result = r_a ^ r_b;
      default:  w_result = 32'd0;
    endcase
  end

  assign w_last     = (r_count == 11'd1);
  assign w_wr_phase = (r_state == S_WR) || (r_state == S_WT_W);

  // Strobe, mask and done are single-cycle: cleared every cycle unless re-armed
  // by the transition that enters RD_x / WR / FIN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_op    <= 2'd0;
      r_ptr_a <= 32'd0;
      r_ptr_b <= 32'd0;
      r_ptr_d <= 32'd0;
      r_count <= 11'd0;
      r_a     <= 32'd0;
      r_b     <= 32'd0;
      r_sel   <= 1'b0;
      r_addr  <= 32'd0;
      r_rstrb <= 1'b0;
      r_wmask <= 4'h0;
      r_done  <= 1'b0;
    end else begin
      r_rstrb <= 1'b0;
      r_wmask <= 4'h0;
      r_done  <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_op    <= op;
            r_ptr_a <= src_a;
            r_ptr_b <= src_b;
            r_ptr_d <= dst;
            r_count <= len;
            r_sel   <= 1'b1;
            r_state <= S_GRANT;
          end
        end
        S_GRANT: begin
          if (r_count != 11'd0) begin
            r_addr  <= r_ptr_a;
            r_rstrb <= 1'b1;
            r_state <= S_RD_A;
          end else begin
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end
        end
        S_RD_A: r_state <= S_WT_A;
        S_WT_A: begin
          if (!pim_rbusy) begin
            r_a     <= pim_rdata;
            r_addr  <= r_ptr_b;
            r_rstrb <= 1'b1;
            r_state <= S_RD_B;
          end
        end
        S_RD_B: r_state <= S_WT_B;
        S_WT_B: begin
          if (!pim_rbusy) begin
            r_b     <= pim_rdata;
            r_addr  <= r_ptr_d;
            r_wmask <= 4'hF;
            r_state <= S_WR;
          end
        end
        S_WR: r_state <= S_WT_W;
        S_WT_W: begin
          if (!pim_wbusy) begin
            r_ptr_a <= r_ptr_a + c_STRIDE;
            r_ptr_b <= r_ptr_b + c_STRIDE;
            r_ptr_d <= r_ptr_d + c_STRIDE;
            r_count <= r_count - 11'd1;
            if (w_last) begin
              r_done  <= 1'b1;
              r_state <= S_FIN;
            end else begin
              r_addr  <= r_ptr_a + c_STRIDE;
              r_rstrb <= 1'b1;
              r_state <= S_RD_A;
            end
          end
        end
        S_FIN: begin
          r_sel   <= 1'b0;
          r_addr  <= 32'd0;
          r_state <= S_IDLE;
        end
        default: begin
          r_sel   <= 1'b0;
          r_addr  <= 32'd0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign pim_sel   = r_sel;
  assign pim_addr  = r_addr;
  assign pim_wdata = w_wr_phase ? w_result : 32'd0;
  assign pim_wmask = r_wmask;
  assign pim_rstrb = r_rstrb;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_pim_vec_engine.sv
`default_nettype none
// ============================================================================
// Module   : tb_pim_vec_engine
// Brief    : Randomized self-checking bench with a RAM model and vector model.
// Revision : 1.0
// ============================================================================
module tb_pim_vec_engine;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, dst;
  logic [10:0] len;
  logic        pim_sel;
  logic [31:0] pim_addr, pim_wdata, pim_rdata;
  logic [3:0]  pim_wmask;
  logic        pim_rstrb, pim_rbusy, pim_wbusy;
  logic        busy, done;

  pim_vec_engine u_dut (
    .clk(clk), .rst(rst), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .dst(dst), .len(len),
    .pim_sel(pim_sel), .pim_addr(pim_addr), .pim_wdata(pim_wdata),
    .pim_wmask(pim_wmask), .pim_rstrb(pim_rstrb),
    .pim_rdata(pim_rdata), .pim_rbusy(pim_rbusy), .pim_wbusy(pim_wbusy),
    .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: 16 KB window, addresses alias modulo the window size
  logic [31:0] mem      [4096];
  logic [31:0] init_mem [4096];
  logic [31:0] model_mem[4096];
  logic        load_req;
  int unsigned r_lat, w_lat, rcnt, wcnt;
  bit          lat_rand;
  logic [31:0] rd_log[$], wa_log[$], wd_log[$];
  int          done_cnt, ovl_cnt;

  logic [31:0] exp_rd[$], exp_wa[$], exp_wd[$];
  logic [1:0]  j_op;
  logic [31:0] j_sa, j_sb, j_d;
  logic [10:0] j_len;

  int n_cmp, n_err;

  assign pim_rdata = mem[pim_addr[13:2]];
  assign pim_rbusy = (rcnt != 0);
  assign pim_wbusy = (wcnt != 0);

  always @(negedge clk) begin
    if (load_req)
      for (int i = 0; i < 4096; i++) mem[i] <= init_mem[i];
    if (!rst) begin
      rcnt <= 0;
      wcnt <= 0;
    end else begin
      if (pim_rstrb) begin
        rd_log.push_back(pim_addr);
        rcnt <= lat_rand ? $urandom_range(r_lat, 0) : r_lat;
      end else if (rcnt != 0) rcnt <= rcnt - 1;
      if (pim_wmask != 4'h0) begin
        wa_log.push_back(pim_addr);
        wd_log.push_back(pim_wdata);
        mem[pim_addr[13:2]] <= pim_wdata;
        wcnt <= lat_rand ? $urandom_range(w_lat, 0) : w_lat;
      end else if (wcnt != 0) wcnt <= wcnt - 1;
      if (done) done_cnt <= done_cnt + 1;
      if (pim_rstrb && pim_wmask != 4'h0) ovl_cnt <= ovl_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < 4096; i++) init_mem[i] = $urandom;
  endtask

  task automatic set_word(input logic [31:0] a, input logic [31:0] v);
    init_mem[a[13:2]] = v;
  endtask

  // Loads RAM and builds the expected transaction stream element by element.
  task automatic prep(input logic [1:0] o, input logic [31:0] sa, input logic [31:0] sb,
                      input logic [31:0] d, input logic [10:0] n);
    logic [31:0] a, b, r, pa, pb, pd;
    j_op = o; j_sa = sa; j_sb = sb; j_d = d; j_len = n;
    model_mem = init_mem;
    exp_rd.delete(); exp_wa.delete(); exp_wd.delete();
    for (int i = 0; i < int'(n); i++) begin
      pa = sa + 32'(4 * i);
      pb = sb + 32'(4 * i);
      pd = d + 32'(4 * i);
      a = model_mem[pa[13:2]];
      b = model_mem[pb[13:2]];
      case (o)
        2'd0: r = a + b;
        2'd1: r = a - b;
        2'd2: r = a & b;
        default: r = a ^ b;
      endcase
      model_mem[pd[13:2]] = r;
      exp_rd.push_back(pa);
      exp_rd.push_back(pb);
      exp_wa.push_back(pd);
      exp_wd.push_back(r);
    end
    load_req = 1'b1;
    @(negedge clk);
    #1 load_req = 1'b0;
  endtask

  task automatic drive_start();
    op = j_op; src_a = j_sa; src_b = j_sb; dst = j_d; len = j_len;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic go(input bit interfere);
    int r0, w0, d0, o0;
    bit ok;
    r0 = rd_log.size(); w0 = wa_log.size(); d0 = done_cnt; o0 = ovl_cnt;
    drive_start();
    #1 chk("busy_after_start", 32'(busy), 32'd1);
    chk("sel_after_start", 32'(pim_sel), 32'd1);
    if (interfere) begin
      repeat (3) @(negedge clk);
      op = ~j_op; dst = j_d + 32'h40; len = 11'd1; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    ok = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      #1;
      if (done_cnt > d0 && !busy) begin ok = 1'b1; break; end
    end
    chk("job_completed", 32'(ok), 32'd1);
    if (interfere) repeat (10) @(negedge clk);
    chk("done_count", 32'(done_cnt - d0), 32'd1);
    chk("sel_after_fin", 32'(pim_sel), 32'd0);
    chk("addr_idle", pim_addr, 32'd0);
    chk("overlap", 32'(ovl_cnt - o0), 32'd0);
    chk("read_count", 32'(rd_log.size() - r0), 32'(exp_rd.size()));
    chk("write_count", 32'(wa_log.size() - w0), 32'(exp_wa.size()));
    for (int i = 0; i < exp_rd.size() && r0 + i < rd_log.size(); i++)
      chk($sformatf("rd_addr[%0d]", i), rd_log[r0 + i], exp_rd[i]);
    for (int i = 0; i < exp_wa.size() && w0 + i < wa_log.size(); i++) begin
      chk($sformatf("wr_addr[%0d]", i), wa_log[w0 + i], exp_wa[i]);
      chk($sformatf("wr_data[%0d]", i), wd_log[w0 + i], exp_wd[i]);
    end
  endtask

  task automatic chk_quiet(input string pfx);
    chk({pfx, "_sel"},   32'(pim_sel),   32'd0);
    chk({pfx, "_addr"},  pim_addr,       32'd0);
    chk({pfx, "_wdata"}, pim_wdata,      32'd0);
    chk({pfx, "_rstrb"}, 32'(pim_rstrb), 32'd0);
    chk({pfx, "_wmask"}, 32'(pim_wmask), 32'd0);
    chk({pfx, "_busy"},  32'(busy),      32'd0);
    chk({pfx, "_done"},  32'(done),      32'd0);
  endtask

  initial begin
    int r0, w0, d0, wbase;
    n_cmp = 0; n_err = 0; done_cnt = 0; ovl_cnt = 0;
    rst = 1'b0; start = 1'b0; op = 2'd0; src_a = 0; src_b = 0; dst = 0; len = 0;
    load_req = 1'b0; r_lat = 0; w_lat = 0; lat_rand = 1'b0;
    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst = 1'b1;

    // single add, zero latency
    fill_random(); set_word(32'h100, 32'h5); set_word(32'h200, 32'h7);
    prep(2'd0, 32'h100, 32'h200, 32'h300, 11'd1);
    go(1'b0);
    chk("add_result", wd_log[wd_log.size() - 1], 32'h0000_000C);

    // sub with fixed bus latencies
    fill_random();
    for (int i = 0; i < 4; i++) begin
      set_word(32'h1000 + 32'(4 * i), 32'(i));
      set_word(32'h2000 + 32'(4 * i), 32'd1);
    end
    r_lat = 3; w_lat = 2;
    prep(2'd1, 32'h1000, 32'h2000, 32'h3000, 11'd4);
    go(1'b0);

    // len = 0 cycle-exact handshake
    r_lat = 0; w_lat = 0;
    prep(2'd0, 32'h10, 32'h20, 32'h30, 11'd0);
    r0 = rd_log.size(); w0 = wa_log.size(); d0 = done_cnt;
    drive_start();
    #1 chk("len0_grant_sel", 32'(pim_sel), 32'd1);
    chk("len0_grant_done", 32'(done), 32'd0);
    @(negedge clk); #1;
    chk("len0_fin_done", 32'(done), 32'd1);
    chk("len0_fin_sel", 32'(pim_sel), 32'd1);
    @(negedge clk); #1;
    chk("len0_idle_sel", 32'(pim_sel), 32'd0);
    chk("len0_idle_busy", 32'(busy), 32'd0);
    chk("len0_txns", 32'((rd_log.size() - r0) + (wa_log.size() - w0)), 32'd0);
    chk("len0_done_cnt", 32'(done_cnt - d0), 32'd1);

    // address wrap: xor source and add destination across 2^32
    fill_random();
    prep(2'd3, 32'hFFFF_FFFC, 32'h0000_0800, 32'h0000_0C00, 11'd2);
    go(1'b0);
    chk("wrap_a_second_read", rd_log[rd_log.size() - 2], 32'h0000_0000);
    fill_random(); set_word(32'h500, 32'hFFFF_FFFF); set_word(32'h600, 32'h1);
    prep(2'd0, 32'h500, 32'h600, 32'hFFFF_FFFC, 11'd2);
    go(1'b0);
    chk("wrap_add_zero", wd_log[wd_log.size() - 2], 32'h0000_0000);
    chk("wrap_dst_second", wa_log[wa_log.size() - 1], 32'h0000_0000);

    // reset while waiting on the third element's write
    fill_random(); r_lat = 0; w_lat = 4;
    prep(2'd0, 32'h1100, 32'h1200, 32'h1300, 11'd4);
    wbase = wa_log.size();
    drive_start();
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk); #1;
      if (wa_log.size() - wbase >= 3) break;
    end
    chk("abort_reached_wr", 32'(wa_log.size() - wbase), 32'd3);
    @(posedge clk); #1;
    rst = 1'b0;
    #1 chk_quiet("abort");
    r0 = rd_log.size(); w0 = wa_log.size(); d0 = done_cnt;
    repeat (5) @(negedge clk);
    chk("abort_no_txn", 32'((rd_log.size() - r0) + (wa_log.size() - w0)), 32'd0);
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    fill_random(); w_lat = 2;
    prep(2'd1, 32'h1100, 32'h1200, 32'h1300, 11'd4);
    rst = 1'b1;
    go(1'b0);

    // start while busy is ignored; in-place update (src == dst)
    fill_random(); r_lat = 1; w_lat = 1;
    prep(2'd2, 32'h2400, 32'h2800, 32'h2400, 11'd4);
    go(1'b1);

    // randomized jobs
    lat_rand = 1'b1;
    for (int k = 0; k < 10; k++) begin
      fill_random();
      r_lat = $urandom_range(3, 0);
      w_lat = $urandom_range(3, 0);
      prep(2'($urandom), $urandom & 32'hFFFF_FFFC, $urandom & 32'hFFFF_FFFC,
           $urandom & 32'hFFFF_FFFC, 11'($urandom_range(12, 0)));
      go(1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
